// File: rtl/sr_cond_pkg.sv
// sr_cond_pkg: shared constants and sizing helper for the set/reset command conditioner.
package sr_cond_pkg;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
   localparam int SYNC_STAGES = 2;
   // Smallest width able to hold cycles-1, never narrower than one bit.
   function automatic int cnt_w_for(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: synchronise, debounce and rising-edge detect one raw button.
module debounce_ch
   import sr_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic deb_q, deb_d, deb_prev_q;
   logic sync, accept;
   assign sync = sync_q[SYNC_STAGES-1];
   // A differing level is accepted only after the counter has run its full span.
   assign accept = (sync != deb_q) && (cnt_q == CNT_MAX);
   always_comb begin
      cnt_d = (sync == deb_q || accept) ? '0 : cnt_q + 1'b1;
      deb_d = accept ? sync : deb_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], btn_i};
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
      end
   end
   assign press_o = deb_q & ~deb_prev_q;
endmodule

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: debounced set/reset presses turned into mutually exclusive one-cycle pulses.
module sr_cmd_conditioner
   import sr_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic reset_btn,
   output logic s,
   output logic r,
   output logic conflict
);
   logic set_press, rst_press;
   logic want_s, want_r;
   logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;
   logic s_pend_q, s_pend_d, r_pend_q, r_pend_d;
   debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
      .clk(clk), .rst_n(rst_n), .btn_i(set_btn), .press_o(set_press)
   );
   debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_rst (
      .clk(clk), .rst_n(rst_n), .btn_i(reset_btn), .press_o(rst_press)
   );
   // Fresh presses join the pending flags in the same cycle so no latency is added.
   always_comb begin
      want_s     = s_pend_q | set_press;
      want_r     = r_pend_q | rst_press;
      s_d        = want_s;
      r_d        = want_r & ~want_s;
      conflict_d = set_press & rst_press;
      s_pend_d   = want_s & ~s_d;
      r_pend_d   = want_r & ~r_d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
         s_pend_q   <= 1'b0;
         r_pend_q   <= 1'b0;
      end else begin
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
         s_pend_q   <= s_pend_d;
         r_pend_q   <= r_pend_d;
      end
   end
   assign s        = s_q;
   assign r        = r_q;
   assign conflict = conflict_q;
endmodule
